// File: rtl/valid_pipe_pkg.sv
// Shared definitions for the valid_pipe delay line and its stage register.
package valid_pipe_pkg;

   // Width needed to hold a count from 0 to n inclusive; never below one bit.
   function automatic int count_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid+data register of the pipeline. It can take a new beat whenever it
// is empty or its own beat is leaving this cycle.
module pipe_stage #(
   parameter int                 DATA_W     = 8,
   parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready
);

   assign in_ready = !out_valid || out_ready;

   // Valid/data register; flush clears only the valid bit so the payload
   // keeps showing the last value held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= RESET_DATA;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/valid_pipe.sv
// N-stage valid/ready delay line. Beats move forward into any stage that is
// empty or draining, so bubbles collapse under backpressure. The ready chain
// is purely combinational from ready_i back to ready_o (no skid buffer).
module valid_pipe
   import valid_pipe_pkg::*;
#(
   parameter int                 DATA_W     = 8,
   parameter int                 STAGES     = 2,
   parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         valid_i,
   input  logic [DATA_W-1:0]            data_i,
   output logic                         ready_o,
   output logic                         valid_o,
   output logic [DATA_W-1:0]            data_o,
   input  logic                         ready_i,
   input  logic                         flush_i,
   output logic [count_w(STAGES)-1:0]   count_o
);

   localparam int CNT_W = count_w(STAGES);

   // Index k is the input of stage k; index k+1 is its output.
   logic [STAGES:0] vld_chain;
   logic [STAGES:0] rdy_chain;
   logic [DATA_W-1:0] dat_chain [0:STAGES];
   logic [CNT_W-1:0]  cnt;

   assign vld_chain[0]      = valid_i;
   assign dat_chain[0]      = data_i;
   assign rdy_chain[STAGES] = ready_i;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipe_stage #(
         .DATA_W     (DATA_W),
         .RESET_DATA (RESET_DATA)
      ) u_stage (
         .clk       (clk_i),
         .rst_n     (rst_n_i),
         .flush     (flush_i),
         .in_valid  (vld_chain[k]),
         .in_data   (dat_chain[k]),
         .in_ready  (rdy_chain[k]),
         .out_valid (vld_chain[k+1]),
         .out_data  (dat_chain[k+1]),
         .out_ready (rdy_chain[k+1])
      );
   end

   assign ready_o = rdy_chain[0];
   assign valid_o = vld_chain[STAGES];
   assign data_o  = dat_chain[STAGES];

   // Occupancy: popcount of the registered stage valid bits.
   always_comb begin
      cnt = '0;
      for (int k = 1; k <= STAGES; k++) begin
         cnt = cnt + CNT_W'(vld_chain[k]);
      end
   end

   assign count_o = cnt;

endmodule
